event_dispatcher: RTL and testbench
===================================

// Module: event_dispatcher
// PURPOSE
// - Issues events to the cores and returns their generated events to the queue; the transmit end of the queue<->core bus observed by core_monitor.
// - Dequeues from the event queue and assigns each event to an idle core (round-robin).
// - Collects per-core output messages and forwards them to the queue enqueue port.
// - Drives msg/sent_msg_vld/rcv_msg_vld/core_id/core_active for the monitor.
// PARAMETERS
// - NUM_CORE 4 : number of cores (power of 2, >=2)
// - NB_COREID $clog2(NUM_CORE) : core id width
// - MSG_WID 32 : message width; [TIME_WID-1:0] = timestamp
// - TIME_WID 16 : timestamp width
// - MAX_SKIP 3 : consecutive cycles a send may lose to returns before it wins
// - GVT_WIN 256 : lookahead window, used only with DISPATCH_GVT_THROTTLE_EN
// PORTS
// - clk           in  1                  clock
// - reset         in  1                  asynchronous, active-high
// - q_msg         in  MSG_WID            head-of-queue event
// - q_vld         in  1                  q_msg valid
// - q_rdy         out 1                  dequeue accept (transfer when q_vld&q_rdy)
// - enq_msg       out MSG_WID            event returned to queue
// - enq_vld       out 1                  enq_msg valid
// - enq_rdy       in  1                  queue can accept
// - core_in_msg   out MSG_WID            event to core (shared bus)
// - core_in_vld   out NUM_CORE           one-hot start pulse per core
// - core_out_msg  in  NUM_CORE*MSG_WID   per-core output message, flattened
// - core_out_vld  in  NUM_CORE           per-core output valid
// - core_out_last in  NUM_CORE           marks core's final message (core done)
// - core_out_ack  out NUM_CORE           one-hot accept of core output
// - msg           out MSG_WID            monitor bus message
// - sent_msg_vld  out 1                  msg is an event sent to core core_id
// - rcv_msg_vld   out 1                  msg is core_id's final (done) message
// - core_id       out NB_COREID          core for sent/rcv
// - core_active   out NUM_CORE           core busy flags
// - min_time      in  TIME_WID           GVT from monitor
// - min_time_vld  in  1                  min_time update strobe
// BEHAVIOUR
// - Reset: all outputs 0 except q_rdy=0; core_active=0, RR pointers=0, skip counter=0, msg bus 0.
// - One transaction per cycle on the shared bus: RETURN or SEND, never both.
// - RETURN eligible: any core_out_vld[c] & enq_rdy & enq output stage free. Core picked round-robin from pointer rr_out; pointer -> picked+1 (mod NUM_CORE).
// - SEND eligible: q_vld & any ~core_active bit & not throttled. Idle core picked round-robin from rr_in.
// - Arbitration: RETURN wins unless skip_cnt==MAX_SKIP; skip_cnt++ on each cycle SEND eligible but lost, cleared on SEND or when SEND not eligible; saturates.
// - q_rdy, core_out_ack are combinational grants in cycle N; effects registered at N+1.
// - SEND at N: N+1 core_in_msg=msg=q_msg, core_in_vld[id]=1 (1 cycle), sent_msg_vld=1, core_id=id, core_active[id]=1.
// - RETURN at N: N+1 enq_msg=msg=core_out_msg[c], enq_vld=1 held until enq_rdy; core_id=c.
// - If core_out_last[c]: also rcv_msg_vld=1 at N+1 and core_active[c] cleared at N+1.
// - Non-last returns: rcv_msg_vld=0, sent_msg_vld=0 (monitor ignores).
// - enq stage busy (enq_vld&~enq_rdy): no RETURN granted; SEND may proceed.
// - All cores active: q_rdy=0. q_vld=0: no SEND, skip_cnt cleared.
// - core_out_vld from an inactive core: still accepted (protocol error, not checked); last from inactive core leaves core_active at 0.
// - Same core's SEND and RETURN impossible same cycle (single grant).
// - Reset mid-operation: asserting reset drops all valids/active asynchronously; in-flight msg lost.
// CONFIGURATION
// - DISPATCH_GVT_THROTTLE_EN defined: register gvt <= min_time on min_time_vld (reset 0); SEND not eligible when q_msg time >= gvt+GVT_WIN (TIME_WID+1-bit compare, no wrap).
// - Undefined: no throttle; min_time/min_time_vld ignored (ports retained).
// TESTING
// - Idle, q_vld=1 time=5 -> next cycle sent_msg_vld=1, core_id=0, core_in_vld=4'b0001, core_active=4'b0001.
// - 5 queued events, no returns -> cores 0,1,2,3 started on consecutive cycles, then q_rdy=0 with core_active=4'b1111.
// - Core 2 active, core_out_vld[2]=1 last=1 -> enq_vld=1, rcv_msg_vld=1, core_id=2, core_active[2]=0 next cycle.
// - Cores 0,1 streaming returns + q_vld=1, MAX_SKIP=3 -> SEND granted on 4th eligible cycle, then returns resume.
// - enq_rdy=0 for 5 cycles with enq_vld held -> core_out_ack=0 throughout, enq_msg stable; SENDs still issued.
// - THROTTLE_EN: min_time=100 strobed, q_msg time=356 -> q_rdy=0; time=355 -> sent next cycle.

Source files
------------

// File: rtl/event_dispatcher.sv
// event_dispatcher: transmit end of the queue<->core bus.
// Pulls events from the queue head and starts them on idle cores, picked round-robin.
// Also collects per-core output messages and pushes them back into the queue.
// The msg/sent_msg_vld/rcv_msg_vld/core_id/core_active outputs feed core_monitor.
// The shared bus carries one transaction per cycle, either a RETURN or a SEND.
// A SEND that keeps losing to RETURNs is forced through after MAX_SKIP lost cycles.
// Optional feature: define DISPATCH_GVT_THROTTLE_EN to hold back events whose
// timestamp is at or beyond the registered GVT plus GVT_WIN.
module event_dispatcher #(
    parameter int NUM_CORE  = 4,
    parameter int NB_COREID = $clog2(NUM_CORE),
    parameter int MSG_WID   = 32,
    parameter int TIME_WID  = 16,
    parameter int MAX_SKIP  = 3,
    parameter int GVT_WIN   = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [MSG_WID-1:0]          q_msg,
    input  logic                        q_vld,
    output logic                        q_rdy,
    output logic [MSG_WID-1:0]          enq_msg,
    output logic                        enq_vld,
    input  logic                        enq_rdy,
    output logic [MSG_WID-1:0]          core_in_msg,
    output logic [NUM_CORE-1:0]         core_in_vld,
    input  logic [NUM_CORE*MSG_WID-1:0] core_out_msg,
    input  logic [NUM_CORE-1:0]         core_out_vld,
    input  logic [NUM_CORE-1:0]         core_out_last,
    output logic [NUM_CORE-1:0]         core_out_ack,
    output logic [MSG_WID-1:0]          msg,
    output logic                        sent_msg_vld,
    output logic                        rcv_msg_vld,
    output logic [NB_COREID-1:0]        core_id,
    output logic [NUM_CORE-1:0]         core_active,
    input  logic [TIME_WID-1:0]         min_time,
    input  logic                        min_time_vld
);

    localparam int SKIP_WID = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);

    logic [NB_COREID-1:0] rr_in_reg;
    logic [NB_COREID-1:0] rr_out_reg;
    logic [SKIP_WID-1:0]  skip_cnt_reg;
    logic [MSG_WID-1:0]   out_msg_arr [NUM_CORE];
    logic [NB_COREID-1:0] out_pick;
    logic                 out_found;
    logic [NB_COREID-1:0] in_pick;
    logic                 in_found;
    logic                 throttled;
    logic                 ret_elig;
    logic                 send_elig;
    logic                 do_send;
    logic                 do_ret;

    // Unflatten the per-core output message bus.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORE; gi++) begin : g_unpack
            assign out_msg_arr[gi] = core_out_msg[gi*MSG_WID +: MSG_WID];
        end
    endgenerate

`ifdef DISPATCH_GVT_THROTTLE_EN
    logic [TIME_WID-1:0] gvt_reg;

    // Latch the monitor's GVT whenever it strobes a new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gvt_reg <= '0;
        end else if (min_time_vld) begin
            gvt_reg <= min_time;
        end
    end

    // The compare is one bit wider than a timestamp so gvt+GVT_WIN never wraps.
    assign throttled = {1'b0, q_msg[TIME_WID-1:0]} >=
                       ({1'b0, gvt_reg} + (TIME_WID+1)'(GVT_WIN));
`else
    logic unused_gvt;
    assign unused_gvt = ^{min_time, min_time_vld};
    assign throttled  = 1'b0;
`endif

    // Round-robin pick of the next returning core, starting at rr_out.
    // The loop runs downwards so that the candidate closest to the pointer wins.
    always_comb begin
        out_pick  = '0;
        out_found = 1'b0;
        for (int k = NUM_CORE - 1; k >= 0; k--) begin
            if (core_out_vld[rr_out_reg + NB_COREID'(k)]) begin
                out_pick  = rr_out_reg + NB_COREID'(k);
                out_found = 1'b1;
            end
        end
    end

    // Round-robin pick of the next idle core, starting at rr_in.
    always_comb begin
        in_pick  = '0;
        in_found = 1'b0;
        for (int k = NUM_CORE - 1; k >= 0; k--) begin
            if (!core_active[rr_in_reg + NB_COREID'(k)]) begin
                in_pick  = rr_in_reg + NB_COREID'(k);
                in_found = 1'b1;
            end
        end
    end

    // enq_rdy high already implies the enq output stage can take a new message.
    assign ret_elig     = out_found & enq_rdy;
    assign send_elig    = q_vld & in_found & ~throttled;
    assign do_send      = send_elig & (~ret_elig | (skip_cnt_reg == SKIP_WID'(MAX_SKIP)));
    assign do_ret       = ret_elig & ~do_send;
    assign q_rdy        = do_send;
    assign core_out_ack = do_ret ? (NUM_CORE'(1) << out_pick) : '0;

    // Count consecutive cycles a pending send loses to returns, saturating at MAX_SKIP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_cnt_reg <= '0;
        end else if (do_send || !send_elig) begin
            skip_cnt_reg <= '0;
        end else if (skip_cnt_reg != SKIP_WID'(MAX_SKIP)) begin
            skip_cnt_reg <= skip_cnt_reg + 1'b1;
        end
    end

    // Advance each round-robin pointer just past the core it last granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_in_reg  <= '0;
            rr_out_reg <= '0;
        end else begin
            if (do_send) rr_in_reg  <= in_pick + 1'b1;
            if (do_ret)  rr_out_reg <= out_pick + 1'b1;
        end
    end

    // Busy flags: set when a core is started, cleared by its final message.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_active <= '0;
        end else if (do_send) begin
            core_active[in_pick] <= 1'b1;
        end else if (do_ret && core_out_last[out_pick]) begin
            core_active[out_pick] <= 1'b0;
        end
    end

    // Enqueue output stage: hold the message until the queue takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enq_vld <= 1'b0;
            enq_msg <= '0;
        end else if (do_ret) begin
            enq_vld <= 1'b1;
            enq_msg <= out_msg_arr[out_pick];
        end else if (enq_rdy) begin
            enq_vld <= 1'b0;
        end
    end

    // Core start bus: one-cycle start pulse to the chosen core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_in_vld <= '0;
            core_in_msg <= '0;
        end else begin
            core_in_vld <= do_send ? (NUM_CORE'(1) << in_pick) : '0;
            if (do_send) core_in_msg <= q_msg;
        end
    end

    // Monitor bus: mirrors whichever transaction won the shared bus last cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg          <= '0;
            sent_msg_vld <= 1'b0;
            rcv_msg_vld  <= 1'b0;
            core_id      <= '0;
        end else begin
            sent_msg_vld <= do_send;
            rcv_msg_vld  <= do_ret & core_out_last[out_pick];
            if (do_send) begin
                msg     <= q_msg;
                core_id <= in_pick;
            end else if (do_ret) begin
                msg     <= out_msg_arr[out_pick];
                core_id <= out_pick;
            end
        end
    end

endmodule

// File: tb/tb_event_dispatcher.sv
// tb_event_dispatcher: directed vectors for event_dispatcher with hand-computed expectations.
// The gvt throttle case adapts to DISPATCH_GVT_THROTTLE_EN.
module tb_event_dispatcher;

    localparam int NUM_CORE  = 4;
    localparam int NB_COREID = 2;
    localparam int MSG_WID   = 32;
    localparam int TIME_WID  = 16;

`ifdef DISPATCH_GVT_THROTTLE_EN
    localparam bit THR = 1'b1;
`else
    localparam bit THR = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        reset;
    logic [MSG_WID-1:0]          q_msg;
    logic                        q_vld;
    logic                        q_rdy;
    logic [MSG_WID-1:0]          enq_msg;
    logic                        enq_vld;
    logic                        enq_rdy;
    logic [MSG_WID-1:0]          core_in_msg;
    logic [NUM_CORE-1:0]         core_in_vld;
    logic [NUM_CORE*MSG_WID-1:0] core_out_msg;
    logic [NUM_CORE-1:0]         core_out_vld;
    logic [NUM_CORE-1:0]         core_out_last;
    logic [NUM_CORE-1:0]         core_out_ack;
    logic [MSG_WID-1:0]          msg;
    logic                        sent_msg_vld;
    logic                        rcv_msg_vld;
    logic [NB_COREID-1:0]        core_id;
    logic [NUM_CORE-1:0]         core_active;
    logic [TIME_WID-1:0]         min_time;
    logic                        min_time_vld;

    int tests_run    = 0;
    int tests_failed = 0;

    event_dispatcher dut (
        .clk           (clk),
        .reset         (reset),
        .q_msg         (q_msg),
        .q_vld         (q_vld),
        .q_rdy         (q_rdy),
        .enq_msg       (enq_msg),
        .enq_vld       (enq_vld),
        .enq_rdy       (enq_rdy),
        .core_in_msg   (core_in_msg),
        .core_in_vld   (core_in_vld),
        .core_out_msg  (core_out_msg),
        .core_out_vld  (core_out_vld),
        .core_out_last (core_out_last),
        .core_out_ack  (core_out_ack),
        .msg           (msg),
        .sent_msg_vld  (sent_msg_vld),
        .rcv_msg_vld   (rcv_msg_vld),
        .core_id       (core_id),
        .core_active   (core_active),
        .min_time      (min_time),
        .min_time_vld  (min_time_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock; return just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_out_msg(input int c, input logic [31:0] v);
        core_out_msg[c*MSG_WID +: MSG_WID] = v;
    endtask

    int          exp_rdy4 [5] = '{0, 0, 0, 1, 0};
    logic [3:0]  exp_ack4 [5] = '{4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0001};
    int          exp_id4  [5] = '{1, 0, 1, 2, 0};
    logic [31:0] exp_enq4 [5] = '{32'hA1, 32'hA0, 32'hA1, 32'hA1, 32'hA0};

    initial begin
        reset         = 1'b1;
        q_msg         = '0;
        q_vld         = 1'b0;
        enq_rdy       = 1'b0;
        core_out_msg  = '0;
        core_out_vld  = '0;
        core_out_last = '0;
        min_time      = '0;
        min_time_vld  = 1'b0;
        set_out_msg(0, 32'hA0);
        set_out_msg(1, 32'hA1);
        set_out_msg(2, 32'hC2C2_0002);
        set_out_msg(3, 32'hD3);

        // Reset state
        repeat (3) tick();
        check("rst_q_rdy",       32'(q_rdy), 32'h0);
        check("rst_enq_vld",     32'(enq_vld), 32'h0);
        check("rst_core_active", 32'(core_active), 32'h0);
        check("rst_core_in_vld", 32'(core_in_vld), 32'h0);
        check("rst_msg",         msg, 32'h0);
        check("rst_sent",        32'(sent_msg_vld), 32'h0);
        reset = 1'b0;

        // Single send from idle
        q_vld = 1'b1;
        q_msg = 32'h0000_0005;
        #1;
        check("t1_q_rdy", 32'(q_rdy), 32'h1);
        tick();
        check("t1_sent",        32'(sent_msg_vld), 32'h1);
        check("t1_core_id",     32'(core_id), 32'h0);
        check("t1_core_in_vld", 32'(core_in_vld), 32'h1);
        check("t1_core_active", 32'(core_active), 32'h1);
        check("t1_msg",         msg, 32'h5);
        check("t1_core_in_msg", core_in_msg, 32'h5);
        q_vld = 1'b0;
        tick();
        check("t1_pulse_end", 32'(core_in_vld), 32'h0);
        check("t1_sent_end",  32'(sent_msg_vld), 32'h0);

        // Asynchronous reset mid-operation clears state without a clock edge
        reset = 1'b1;
        #1;
        check("arst_core_active", 32'(core_active), 32'h0);
        tick();
        reset = 1'b0;

        // Five queued events: cores 0..3 started, then queue stalls
        for (int i = 0; i < 5; i++) begin
            q_vld = 1'b1;
            q_msg = 32'h100 + 32'(i);
            #1;
            check($sformatf("t2_q_rdy_%0d", i), 32'(q_rdy), (i < 4) ? 32'h1 : 32'h0);
            tick();
            if (i < 4) begin
                check($sformatf("t2_core_id_%0d", i), 32'(core_id), 32'(i));
                check($sformatf("t2_in_vld_%0d", i), 32'(core_in_vld), 32'h1 << i);
                check($sformatf("t2_active_%0d", i), 32'(core_active), (32'h2 << i) - 32'h1);
            end else begin
                check("t2_active_full", 32'(core_active), 32'hF);
                check("t2_no_start",    32'(core_in_vld), 32'h0);
            end
        end
        q_vld = 1'b0;

        // Final message from core 2
        enq_rdy       = 1'b1;
        core_out_vld  = 4'b0100;
        core_out_last = 4'b0100;
        #1;
        check("t3_ack", 32'(core_out_ack), 32'h4);
        tick();
        check("t3_enq_vld", 32'(enq_vld), 32'h1);
        check("t3_enq_msg", enq_msg, 32'hC2C2_0002);
        check("t3_rcv",     32'(rcv_msg_vld), 32'h1);
        check("t3_sent",    32'(sent_msg_vld), 32'h0);
        check("t3_core_id", 32'(core_id), 32'h2);
        check("t3_active",  32'(core_active), 32'hB);

        // Non-final message from core 0: no rcv, core stays active
        core_out_vld  = 4'b0001;
        core_out_last = 4'b0000;
        #1;
        check("t3b_ack", 32'(core_out_ack), 32'h1);
        tick();
        check("t3b_rcv",     32'(rcv_msg_vld), 32'h0);
        check("t3b_core_id", 32'(core_id), 32'h0);
        check("t3b_active",  32'(core_active), 32'hB);
        check("t3b_enq_msg", enq_msg, 32'hA0);

        // Cores 0,1 streaming returns against a pending send: send wins on the 4th cycle
        core_out_vld = 4'b0011;
        q_vld        = 1'b1;
        q_msg        = 32'h0000_0020;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t4_q_rdy_%0d", i), 32'(q_rdy), 32'(exp_rdy4[i]));
            check($sformatf("t4_ack_%0d", i),   32'(core_out_ack), 32'(exp_ack4[i]));
            tick();
            check($sformatf("t4_core_id_%0d", i), 32'(core_id), 32'(exp_id4[i]));
            check($sformatf("t4_enq_msg_%0d", i), enq_msg, exp_enq4[i]);
        end
        check("t4_active", 32'(core_active), 32'hF);
        q_vld        = 1'b0;
        core_out_vld = 4'b0000;

        // Release core 3 so a send can proceed while the enq stage stalls
        core_out_vld  = 4'b1000;
        core_out_last = 4'b1000;
        #1;
        check("t5_ack3", 32'(core_out_ack), 32'h8);
        tick();
        check("t5_active", 32'(core_active), 32'h7);
        check("t5_enq_msg", enq_msg, 32'hD3);
        core_out_last = 4'b0000;

        // enq_rdy low for 5 cycles: no acks, enq_msg held, send still issued
        enq_rdy      = 1'b0;
        core_out_vld = 4'b0011;
        q_vld        = 1'b1;
        q_msg        = 32'h0000_0040;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t5_ack_%0d", i),   32'(core_out_ack), 32'h0);
            check($sformatf("t5_q_rdy_%0d", i), 32'(q_rdy), (i == 0) ? 32'h1 : 32'h0);
            tick();
            check($sformatf("t5_enq_vld_%0d", i), 32'(enq_vld), 32'h1);
            check($sformatf("t5_enq_hold_%0d", i), enq_msg, 32'hD3);
            if (i == 0) begin
                check("t5_sent",    32'(sent_msg_vld), 32'h1);
                check("t5_sent_id", 32'(core_id), 32'h3);
            end
        end
        q_vld   = 1'b0;
        enq_rdy = 1'b1;
        #1;
        check("t5_resume_ack", 32'(core_out_ack), 32'h1);
        tick();
        check("t5_resume_enq", enq_msg, 32'hA0);
        core_out_vld = 4'b0000;

        // GVT throttle: time 356 is held back only when the throttle is built in
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        min_time     = 16'd100;
        min_time_vld = 1'b1;
        tick();
        min_time_vld = 1'b0;
        q_vld        = 1'b1;
        q_msg        = 32'd356;
        #1;
        check("t6_q_rdy_356", 32'(q_rdy), THR ? 32'h0 : 32'h1);
        q_msg = 32'd355;
        #1;
        check("t6_q_rdy_355", 32'(q_rdy), 32'h1);
        tick();
        check("t6_sent",    32'(sent_msg_vld), 32'h1);
        check("t6_msg",     msg, 32'd355);
        q_vld = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
